// File: rtl/uart_tx_p.sv
// uart_tx_p: parametrised UART transmitter with an internal bit-rate divider
// and a small word FIFO. The frame is a start bit, DATA_BITS data bits sent
// LSB first, an optional parity bit, and STOP_BITS stop bits. The line idles
// high.
//
// Handshake: a word is transferred on every rising clk edge where data_rdy and
// ready are both high. ready is derived only from the registered FIFO level,
// so it never depends combinationally on data_rdy.
module uart_tx_p #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV       = 16,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_BITS-1:0]         data,
  input  logic                         data_rdy,
  output logic                         ready,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         out
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;
  logic                 head_par;

  assign ready     = (level != LW'(DEPTH));
  assign push      = data_rdy && ready;
  assign head      = mem[rd_ptr];
  assign bit_end   = (cnt == CW'(DIV - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  // Parity bit that goes with the head word: even parity is the XOR of the
  // data, odd parity its complement.
  assign head_par  = (PARITY == 1) ? ~^head : ^head;

  // A word leaves the FIFO when the FSM is idle, or at the very end of the last
  // stop bit so the next start bit follows with no gap.
  always_comb begin
    pop = 1'b0;
    if (level != '0) begin
      if (state == ST_IDLE) begin
        pop = 1'b1;
      end else if (state == ST_STOP && bit_end && last_stop) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO storage: written on an accepted word; contents need no reset because
  // level and the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers and level; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Transmit FSM with bit-period counter; out and busy are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      out      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      if (state == ST_IDLE || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg   <= head;
            par_bit <= head_par;
            out     <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            out     <= shreg[0];
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                out   <= par_bit;
                state <= ST_PAR;
              end else begin
                out      <= 1'b1;
                stop_idx <= 1'b0;
                state    <= ST_STOP;
              end
            end else begin
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              out     <= shreg[1];
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end

        ST_PAR: begin
          if (bit_end) begin
            out      <= 1'b1;
            stop_idx <= 1'b0;
            state    <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              if (pop) begin
                shreg   <= head;
                par_bit <= head_par;
                out     <= 1'b0;
                state   <= ST_START;
              end else begin
                out   <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end

        default: begin
          out   <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_p.md
# uart_tx_p

Parametrised UART transmitter, successor to the fixed 8n1 transmitter. It runs from the fabric system clock with an internal bit-rate divider, so no separate baud clock is needed. It buffers words in a small internal FIFO and supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. It sits between a word producer (CPU bus, packetiser, external FIFO) and a physical TX pin.

## Interface
- DATA_BITS, 8: data bits per frame; legal values 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- DIV, 16: clk cycles per UART bit; must be ≥ 2.
- DEPTH, 4: FIFO depth in words; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- data  in  DATA_BITS  word to transmit; sent LSB first.
- data_rdy  in  1  write request; level-sensitive.
- ready  out  1  high when the FIFO can accept a word; equals (level != DEPTH).
- busy  out  1  high while a frame is on the line, from start bit through the last stop bit.
- level  out  $clog2(DEPTH+1)  number of words currently in the FIFO.
- out  out  1  UART line; idles high.

## Operation
- **Write:** a word is accepted on any clk edge with data_rdy=1 and ready=1. One word is accepted per edge. data_rdy held high writes on every edge.
- **No combinational path:** ready and level derive only from registered state, never from data_rdy.
- **Transmitter FSM:** IDLE → START → DATA → PARITY → STOP → (START | IDLE).
  - IDLE: if level > 0, pop the head word into the shift register, drive out=0 and go to START.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: skipped when PARITY=0.
    - Odd: the parity bit makes the total count of ones (data + parity) odd.
    - Even: the parity bit makes that total even.
  - STOP: out=1 for STOP_BITS bit periods. At the end, if level > 0, pop the next word and go straight to START with no idle gap; otherwise go to IDLE.
- **Bit timing:** a bit-period counter runs 0..DIV-1. Every bit, including each stop bit, lasts exactly DIV cycles.
- **Frame length:** (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × DIV cycles.
- **Simultaneous write and pop** (level between 1 and DEPTH-1): level is unchanged and FIFO order is preserved.
- **Write into an empty FIFO while IDLE:** the word is stored, then popped on the next edge.
- **Full FIFO:** ready=0, so data_rdy is ignored and no word is overwritten. A pop on that edge does not enable a same-edge write.
- **Read/write pointers** wrap modulo DEPTH.
- **Reset values:** out=1, busy=0, ready=1, level=0, FSM=IDLE, counters=0.
- **Reset mid-frame:** the frame is abandoned. out=1 from the next edge and the FIFO contents are discarded. No partial frame resumes.

## Timing
- **Write latency:** word written at edge N into an empty FIFO with the FSM idle:
  - the start bit (out=0) appears after edge N+1;
  - busy rises after edge N+1;
  - level reads 1 after N and 0 after N+1.
- **busy:** stays high continuously across back-to-back frames and falls after the edge that ends the last stop bit.
- **ready:** deasserts after the edge that makes level = DEPTH and reasserts after the first pop.
- **out:** is registered, so there are no glitches between bit boundaries.

## Test plan
- **Even parity:** DIV=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; write 0xA5 → out = 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles. busy is high for exactly 44 cycles, then out=1 and level=0.
- **Odd parity, narrow word:** PARITY=1, DATA_BITS=7; write 0x00 → parity bit = 1. Write 0x7F → parity bit = 0.
- **Fill and overflow:** DEPTH=4, DIV=4; hold data_rdy with values 1..6 on consecutive edges →
  - words 1–5 are accepted and ready drops after the 5th;
  - word 6 is accepted only after the first frame ends;
  - six frames are sent in order with no idle cycles between stop and start.
- **Two stop bits:** STOP_BITS=2; write two words back-to-back → stop is high for 2×DIV cycles, then the second start bit follows immediately.
- **Reset mid-frame:** assert rst during data bit 3 with 2 words queued → after the next edge, out=1, busy=0, level=0 and ready=1. No further frames follow until a new write.
- **Concurrent write and pop:** write on the same edge as a pop with level=2 → level stays 2 and the transmitted order matches the write order.
